// File: rtl/vinstr_queue.sv
// ============================================================================
// vinstr_queue
// ----------------------------------------------------------------------------
// In-order instruction queue between the scalar core's dispatch stage and the
// vector decode stage. Instructions leave in exactly the order they arrived.
// A flush from the scalar core (mispredict or exception) discards everything
// queued.
//
// Parameters
//   INSTRUCTION_LENGTH : width of one vector instruction word (default 32)
//   DEPTH              : number of entries, power of two, 2..64 (default 8)
//
// Ports
//   clk_i         in   single clock, rising edge
//   rstn_i        in   asynchronous active-low reset
//   flush_i       in   discard all queued instructions
//   instruction_i in   instruction from scalar dispatch
//   valid_i       in   instruction_i valid
//   ready_o       out  queue can accept instruction_i
//   instruction_o out  head instruction (zero when valid_o is low)
//   valid_o       out  instruction_o valid
//   ready_i       in   downstream accepts instruction_o
//   count_o       out  number of stored entries
//   full_o        out  count_o == DEPTH
//   empty_o       out  count_o == 0
//
// Build option
//   VINSTR_QUEUE_BYPASS_EN : when defined, an empty queue forwards
//   instruction_i straight to instruction_o in the same cycle; the word is
//   stored only if downstream does not take it. When undefined there is no
//   combinational input-to-output path and push-to-valid latency is 1 cycle.
// ============================================================================
module vinstr_queue #(
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int DEPTH              = 8
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          flush_i,
    input  logic [INSTRUCTION_LENGTH-1:0] instruction_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [INSTRUCTION_LENGTH-1:0] instruction_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Storage is never reset; instruction_o is masked to zero whenever
    // valid_o is low, so stale contents never reach the outputs.
    logic [INSTRUCTION_LENGTH-1:0] mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign count_o = count;
    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    // Depends only on registered state and flush_i; ready_i never feeds it.
    assign ready_o = !full_o && !flush_i;

    always_comb begin
        valid_o       = !empty_o && !flush_i;
        instruction_o = valid_o ? mem[rd_ptr] : '0;
        push          = valid_i && ready_o;
        pop           = valid_o && ready_i;
`ifdef VINSTR_QUEUE_BYPASS_EN
        // Empty and not flushing: present the incoming word directly. If
        // downstream takes it now it is never stored; otherwise it becomes
        // an ordinary push. The stored queue is empty, so nothing pops.
        if (empty_o && !flush_i) begin
            valid_o       = valid_i;
            instruction_o = valid_i ? instruction_i : '0;
            push          = valid_i && !ready_i;
            pop           = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            // Flush outranks everything; push and pop are already blocked
            // by ready_o/valid_o being low this cycle.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly PW bits, so DEPTH-1 wraps to 0 naturally.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= instruction_i;
    end

endmodule

// File: tb/tb_vinstr_queue.sv
// ============================================================================
// tb_vinstr_queue
// ----------------------------------------------------------------------------
// Directed scoreboard bench for vinstr_queue. The stimulus process queues
// the expected output word for every instruction it expects to be accepted;
// a monitor on the falling edge pops and compares whenever the DUT presents
// a transfer (valid_o && ready_i). Status outputs are checked inline against
// hand-computed constants.
// ============================================================================
module tb_vinstr_queue;

    localparam int IL = 32;
    localparam int D  = 8;

    logic          clk;
    logic          rstn;
    logic          flush;
    logic [IL-1:0] instr_in;
    logic          vld_in;
    logic          rdy_out;
    logic [IL-1:0] instr_out;
    logic          vld_out;
    logic          rdy_in;
    logic [3:0]    count;
    logic          full;
    logic          empty;

    int checks   = 0;
    int failures = 0;

    logic [IL-1:0] exp_q [$];

    vinstr_queue #(.INSTRUCTION_LENGTH(IL), .DEPTH(D)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .flush_i       (flush),
        .instruction_i (instr_in),
        .valid_i       (vld_in),
        .ready_o       (rdy_out),
        .instruction_o (instr_out),
        .valid_o       (vld_out),
        .ready_i       (rdy_in),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs; record the word as expected output if it should be taken.
    task automatic drive(input logic v, input logic [IL-1:0] d, input logic r, input logic acc);
        vld_in   = v;
        instr_in = d;
        rdy_in   = r;
        if (acc) exp_q.push_back(d);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(rdy_out), 64'd1);
        chk({tag, "_valid"}, 64'(vld_out), 64'd0);
        chk({tag, "_instr"}, 64'(instr_out), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_full"},  64'(full), 64'd0);
    endtask

    // Monitor: compare every presented transfer against the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            if (vld_out && rdy_in) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(instr_out), 64'hDEAD_0000);
                end else begin
                    chk("out_data", 64'(instr_out), 64'(exp_q.pop_front()));
                end
            end else if (!vld_out) begin
                chk("idle_zero", 64'(instr_out), 64'd0);
            end
        end
    end

    initial begin
        rstn     = 1'b0;
        flush    = 1'b0;
        vld_in   = 1'b0;
        rdy_in   = 1'b0;
        instr_in = '0;
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        #1;
        rstn = 1'b1;
        step();

`ifdef VINSTR_QUEUE_BYPASS_EN
        // Same-cycle pass-through into an empty queue, not stored.
        drive(1'b1, 32'hABCD_1257, 1'b1, 1'b1);
        chk("byp_valid", 64'(vld_out), 64'd1);
        chk("byp_instr", 64'(instr_out), 64'hABCD_1257);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("byp_count", 64'(count), 64'd0);
`else
        // Single push, one-cycle latency, pop.
        drive(1'b1, 32'h0000_0057, 1'b1, 1'b1);
        chk("lat_no_comb", 64'(vld_out), 64'd0);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("single_count1", 64'(count), 64'd1);
        chk("single_valid", 64'(vld_out), 64'd1);
        chk("single_instr", 64'(instr_out), 64'h57);
        step();
        chk("single_count0", 64'(count), 64'd0);
        chk("single_empty", 64'(empty), 64'd1);
`endif

        // Fill to full with downstream stalled.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, IL'(i), 1'b0, 1'b1);
            step();
        end
        drive(1'b1, 32'h9, 1'b0, 1'b0);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_ready", 64'(rdy_out), 64'd0);
        chk("full_count", 64'(count), 64'd8);
        chk("stall_head", 64'(instr_out), 64'd1);
        step();
        chk("ninth_ignored", 64'(count), 64'd8);
        chk("stall_head_hold", 64'(instr_out), 64'd1);
        // Full with a pop: ready stays low this cycle, slot usable next.
        drive(1'b1, 32'h99, 1'b1, 1'b0);
        chk("full_pop_ready", 64'(rdy_out), 64'd0);
        step();
        chk("after_pop_count", 64'(count), 64'd7);
        drive(1'b1, 32'h99, 1'b1, 1'b1);
        chk("freed_ready", 64'(rdy_out), 64'd1);
        step();
        chk("push_pop_count", 64'(count), 64'd7);
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step();
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_empty", 64'(empty), 64'd1);

        // Steady push+pop at count 4 across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, IL'(32'h100 + i), 1'b0, 1'b1);
            step();
        end
        chk("wrap_pre_count", 64'(count), 64'd4);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, IL'(32'h104 + k), 1'b1, 1'b1);
            step();
            chk("wrap_count", 64'(count), 64'd4);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("wrap_drain", 64'(count), 64'd0);

        // Flush at count 5 with a push attempted in the flush cycle.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, IL'(32'h200 + i), 1'b0, 1'b1);
            step();
        end
        chk("flush_pre_count", 64'(count), 64'd5);
        flush = 1'b1;
        drive(1'b1, 32'h2FF, 1'b1, 1'b0);
        exp_q.delete();
        chk("flush_valid", 64'(vld_out), 64'd0);
        chk("flush_ready", 64'(rdy_out), 64'd0);
        chk("flush_instr", 64'(instr_out), 64'd0);
        step();
        flush = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("post_flush_count", 64'(count), 64'd0);
        chk("post_flush_empty", 64'(empty), 64'd1);
        chk("post_flush_valid", 64'(vld_out), 64'd0);
        drive(1'b1, 32'h300, 1'b1, 1'b1);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        chk("post_flush_drain", 64'(count), 64'd0);

        // Asynchronous reset mid-stream at count 3.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, IL'(32'h400 + i), 1'b0, 1'b1);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("arst_pre_count", 64'(count), 64'd3);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("arst");
        exp_q.delete();
        @(negedge clk);
        #1;
        rstn = 1'b1;
        step();
        drive(1'b1, 32'h500, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("post_arst_count", 64'(count), 64'd1);
        chk("post_arst_head", 64'(instr_out), 64'h500);
        step();
        step();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vinstr_queue.md
VINSTR_QUEUE -- requirements
Module: vinstr_queue

Interface
REQ-001 SHALL have parameter INSTRUCTION_LENGTH, default 32: width of one vector instruction word.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries; power of two, 2..64.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discard all queued instructions (mispredict/exception from scalar core).
REQ-006 SHALL have port instruction_i  input  INSTRUCTION_LENGTH  instruction from scalar dispatch.
REQ-007 SHALL have port valid_i  input  1  instruction_i valid.
REQ-008 SHALL have port ready_o  output  1  queue can accept instruction_i.
REQ-009 SHALL have port instruction_o  output  INSTRUCTION_LENGTH  head instruction, drives vdecode instruction_i.
REQ-010 SHALL have port valid_o  output  1  instruction_o valid.
REQ-011 SHALL have port ready_i  input  1  downstream (vdecode/issue) accepts instruction_o.
REQ-012 SHALL have port count_o  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 SHALL have ports full_o, empty_o  output  1 each  count_o==DEPTH, count_o==0.

Function
REQ-014 Push SHALL occur on a rising edge where valid_i && ready_o; pop where valid_o && ready_i.
REQ-015 Instructions SHALL leave in exact arrival order (FIFO); no reordering, duplication or loss except on flush.
REQ-016 ready_o SHALL equal !full_o && !flush_i, derived from registered state only (no ready_i->ready_o path).
REQ-017 Full with simultaneous pop: ready_o SHALL stay 0 that cycle; freed slot usable next cycle.
REQ-018 valid_o SHALL equal !empty_o && !flush_i (bypass per REQ-027).
REQ-019 instruction_o SHALL be the head entry when valid_o=1 and all zeros when valid_o=0.
REQ-020 Push-to-valid_o latency SHALL be 1 cycle when the queue is empty (bypass off).
REQ-021 Simultaneous push and pop with 0<count<DEPTH: count_o SHALL remain unchanged; both operations take effect.
REQ-022 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no lost entry.
REQ-023 flush_i=1 SHALL, at the next edge, clear pointers and count_o to 0; any push or pop attempted in that cycle SHALL be discarded; flush wins over all other events.
REQ-024 Holding valid_o with ready_i=0 SHALL keep instruction_o stable until the pop.

Reset
REQ-025 rstn_i=0 SHALL immediately and asynchronously set pointers and count to 0: ready_o=1, valid_o=0, instruction_o=0, count_o=0, empty_o=1, full_o=0; reset mid-stream discards all contents.
REQ-026 Storage array SHALL NOT require reset; outputs stay deterministic via REQ-019.

Configuration
REQ-027 Macro VINSTR_QUEUE_BYPASS_EN defined: when empty and not flushing, valid_o=valid_i and instruction_o=instruction_i combinationally; if ready_i=1 the instruction passes in the same cycle and is not stored (count stays 0); if ready_i=0 it is stored as a normal push.
REQ-028 Macro VINSTR_QUEUE_BYPASS_EN undefined: no combinational input-to-output path; REQ-020 latency applies.

Verification
REQ-029 Reset, then push 0x00000057 (vadd.vv pattern), ready_i=1 -> valid_o=1 one cycle later with instruction_o=0x00000057, count_o 1->0 after pop.
REQ-030 ready_i=0, push 8 distinct words 0x1..0x8 -> full_o=1, ready_o=0, 9th valid_i ignored; release ready_i -> outputs 0x1..0x8 in order over 8 cycles.
REQ-031 count_o=4, valid_i=1 and ready_i=1 for 20 cycles with incrementing data -> count_o stays 4, data in order across pointer wrap.
REQ-032 count_o=5, assert flush_i with valid_i=1 -> valid_o=0 and ready_o=0 in flush cycle; next cycle count_o=0, empty_o=1, flushed push absent.
REQ-033 Drop rstn_i mid-stream at count_o=3 (no clock edge) -> outputs at reset values immediately.
REQ-034 With VINSTR_QUEUE_BYPASS_EN, empty queue, push 0xABCD1257 with ready_i=1 -> valid_o=1 and instruction_o=0xABCD1257 same cycle, count_o stays 0.
